// File: rtl/hamdec_arbiter.sv
// hamdec_arbiter
//
// Round-robin scheduler sharing one Hamming(7,4) single-error-correcting
// decode stage among four requester channels. One channel is granted per
// cycle; its codeword is decoded and captured in a registered output port
// tagged with the source channel.
//
// Build option:
//   HAMDEC_ERRCNT_EN  when defined, builds four CNT_W-bit saturating
//                     per-channel corrected-error counters, the cnt_clr clear
//                     and the cnt_sel readout mux. When undefined, no counter
//                     registers exist, cnt_val is tied to 0 and cnt_sel /
//                     cnt_clr are ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-channel request valid (bit i = channel i)
//   req_code   four 7-bit codewords, channel i at [7i+6:7i], bit 0 = y[0]
//   req_ready  per-channel accept, combinational, at most one bit high
//   out_valid  output register holds a result
//   out_ready  downstream accepts the result
//   out_code   corrected codeword c[6:0]
//   out_data   corrected data bits c[6:3]
//   out_chan   channel that supplied the word
//   out_err    a single-bit correction was applied
//   out_syn    raw syndrome {s2,s1,s0}
//   cnt_sel    selects which channel counter cnt_val shows
//   cnt_val    error count of the selected channel, combinational
//   cnt_clr    synchronously clears all counters

module hamdec_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [27:0]      req_code,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic [3:0]       out_data,
  output logic [1:0]       out_chan,
  output logic             out_err,
  output logic [2:0]       out_syn,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_val,
  input  logic             cnt_clr
);

  logic [1:0] rr_ptr;
  logic [1:0] sel_chan;
  logic [1:0] idx;
  logic       found;
  logic [3:0] grant;
  logic       stall;
  logic       accept;
  logic [6:0] sel_code;
  logic [2:0] syn;
  logic [6:0] flip;
  logic [6:0] corr;

  // Rotating-priority search starting at rr_ptr; the first valid channel wins.
  always_comb begin
    found    = 1'b0;
    sel_chan = rr_ptr;
    idx      = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + k[1:0];
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        sel_chan = idx;
      end
    end
    grant = found ? (4'b0001 << sel_chan) : 4'b0000;
  end

  // A grant only becomes a ready when the output slot can take a word, so
  // accept already implies req_valid & req_ready on the selected channel.
  assign stall     = out_valid & ~out_ready;
  assign accept    = found & ~stall & ~rst;
  assign req_ready = accept ? grant : 4'b0000;

  always_comb begin
    sel_code = req_code[6:0];
    case (sel_chan)
      2'd0: sel_code = req_code[6:0];
      2'd1: sel_code = req_code[13:7];
      2'd2: sel_code = req_code[20:14];
      2'd3: sel_code = req_code[27:21];
      default: sel_code = req_code[6:0];
    endcase
  end

  // Syndrome is the XOR of parity-check columns of the set bits; it names
  // the column of the single bit to flip.
  assign syn[0] = sel_code[0] ^ sel_code[3] ^ sel_code[5] ^ sel_code[6];
  assign syn[1] = sel_code[1] ^ sel_code[3] ^ sel_code[4] ^ sel_code[5];
  assign syn[2] = sel_code[2] ^ sel_code[4] ^ sel_code[5] ^ sel_code[6];

  always_comb begin
    flip = 7'b0000000;
    case (syn)
      3'b001: flip = 7'b0000001;
      3'b010: flip = 7'b0000010;
      3'b100: flip = 7'b0000100;
      3'b011: flip = 7'b0001000;
      3'b110: flip = 7'b0010000;
      3'b111: flip = 7'b0100000;
      3'b101: flip = 7'b1000000;
      default: flip = 7'b0000000;
    endcase
  end

  assign corr = sel_code ^ flip;

  // Output slot: a new accept always overwrites (covers drain+accept in one
  // cycle); a drain alone only drops out_valid so the fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_chan  <= '0;
      out_err   <= 1'b0;
      out_syn   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_code  <= corr;
      out_chan  <= sel_chan;
      out_err   <= |syn;
      out_syn   <= syn;
      rr_ptr    <= sel_chan + 2'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = out_code[6:3];

`ifdef HAMDEC_ERRCNT_EN
  logic [CNT_W-1:0] cnt [4];

  // Saturating per-channel counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else if (accept && (syn != 3'b000) && (cnt[sel_chan] != '1)) begin
      cnt[sel_chan] <= cnt[sel_chan] + CNT_W'(1);
    end
  end

  assign cnt_val = cnt[cnt_sel];
`else
  logic unused_cnt_ports;

  assign unused_cnt_ports = ^{cnt_sel, cnt_clr};
  assign cnt_val          = '0;
`endif

endmodule
